// File: rtl/ltpi_pkg.sv
// Shared LTPI data-channel types: payload layout, command codes, link states
// and the controller-side Avalon-MM FSM encoding.
package ltpi_pkg;

   localparam int TIMER_1MS_60MHZ          = 60000;
   localparam int DATA_CHNL_TIMEOUT_CYCLES = 10 * TIMER_1MS_60MHZ;
   localparam int TAG_W                    = 4;

   localparam logic [7:0] READ_REQ   = 8'h00;
   localparam logic [7:0] WRITE_REQ  = 8'h01;
   localparam logic [7:0] READ_COMP  = 8'h02;
   localparam logic [7:0] WRITE_COMP = 8'h03;
   localparam logic [7:0] CRC_ERROR  = 8'h04;

   localparam logic [1:0] AVMM_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AVMM_RESP_SLVERR = 2'b10;

   typedef enum logic [3:0] {
      link_detect_st,
      link_speed_st,
      link_cfg_st,
      operational_st,
      link_lost_st
   } link_state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [7:0]       command;
      logic [31:0]      address;
      logic [3:0]       operation_status;
      logic [3:0]       byte_en;
      logic [3:0][7:0]  data;
   } Data_channel_payload_t;

   typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} ctrl_avmm_fsm_t;

   // Expands a 4-bit byte enable into a 32-bit lane mask.
   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) m[8*b +: 8] = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/logic_avalon_mm_if.sv
// Avalon-MM bus bundle with host (master) and endpoint (slave) views.
interface logic_avalon_mm_if;
   logic            chipselect;
   logic            read;
   logic            write;
   logic [31:0]     address;
   logic [3:0][7:0] writedata;
   logic [3:0]      byteenable;
   logic [3:0][7:0] readdata;
   logic            readdatavalid;
   logic            waitrequest;
   logic [1:0]      response;

   modport slave (
      input  chipselect, read, write, address, writedata, byteenable,
      output readdata, readdatavalid, waitrequest, response
   );

   modport master (
      output chipselect, read, write, address, writedata, byteenable,
      input  readdata, readdatavalid, waitrequest, response
   );
endinterface

// File: rtl/ltpi_timeout_timer.sv
// Response timeout counter: cleared by i_clear, counts while i_start is high
// and flags o_done once CYCLES-1 is reached (then holds there).
module ltpi_timeout_timer #(
   parameter int CYCLES = 100
) (
   input  logic clk,
   input  logic i_clear,
   input  logic i_start,
   output logic o_done
);
   localparam int CNT_W = $clog2(CYCLES + 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_count <= '0;
      end else if (i_start && !o_done) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_done = (r_count == CNT_W'(CYCLES - 1));

endmodule

// File: rtl/ltpi_data_channel_controller_mm.sv
// LTPI data-channel controller endpoint: turns one Avalon-MM access at a time
// into a READ_REQ/WRITE_REQ payload and completes it from the returned payload.
module ltpi_data_channel_controller_mm
   import ltpi_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DATA_CHNL_TIMEOUT_CYCLES,
   parameter int MAX_RETRIES    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  data_channel_rst,
   logic_avalon_mm_if.slave      avalon_mm_s,
   output Data_channel_payload_t req,
   output logic                  req_valid,
   input  logic                  req_ack,
   input  Data_channel_payload_t resp,
   input  logic                  resp_valid,
   input  logic                  frm_crc_error,
   input  link_state_t           local_link_state
);
   localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

   ctrl_avmm_fsm_t        r_state;
   Data_channel_payload_t r_req;
   logic                  r_req_valid;
   logic [TAG_W-1:0]      r_tag;
   logic [RETRY_W-1:0]    r_retry;
   logic                  r_waitreq;
   logic                  r_rdv;
   logic [31:0]           r_rdata;
   logic [1:0]            r_resp;

   logic       w_rst;
   logic       w_access;
   logic       w_link_up;
   logic       w_is_write;
   logic [7:0] w_exp_cmd;
   logic       w_match;
   logic       w_crc;
   logic       w_retry_ok;
   logic       w_timeout;
   logic       w_tmr_clear;
   logic       w_tmr_run;

   assign w_rst      = reset | data_channel_rst;
   assign w_access   = avalon_mm_s.chipselect & (avalon_mm_s.read | avalon_mm_s.write);
   assign w_link_up  = (local_link_state == operational_st);
   assign w_is_write = (r_req.command == WRITE_REQ);
   assign w_exp_cmd  = w_is_write ? WRITE_COMP : READ_COMP;
   assign w_match    = resp_valid && !frm_crc_error && (resp.tag == r_req.tag)
                       && (resp.command == w_exp_cmd);
   // A corrupted frame cannot be trusted for its tag, so it counts as ours.
   assign w_crc      = resp_valid && ((resp.command == CRC_ERROR) || frm_crc_error)
                       && ((resp.tag == r_req.tag) || frm_crc_error);
   assign w_retry_ok = (int'(r_retry) < MAX_RETRIES);

   assign w_tmr_clear = w_rst || (r_state != WAIT);
   assign w_tmr_run   = (r_state == WAIT);

   ltpi_timeout_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .i_clear (w_tmr_clear),
      .i_start (w_tmr_run),
      .o_done  (w_timeout)
   );

   always_ff @(posedge clk) begin
      if (w_rst) begin
         r_state     <= IDLE;
         r_req       <= '0;
         r_req_valid <= 1'b0;
         r_tag       <= '0;
         r_retry     <= '0;
         r_waitreq   <= 1'b1;
         r_rdv       <= 1'b0;
         r_rdata     <= '0;
         r_resp      <= AVMM_RESP_OKAY;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access) begin
                  if (!w_link_up) begin
                     r_resp    <= AVMM_RESP_SLVERR;
                     r_rdata   <= '0;
                     r_waitreq <= 1'b0;
                     r_rdv     <= !avalon_mm_s.write;
                     r_state   <= DONE;
                  end else begin
                     r_req.tag              <= r_tag;
                     r_req.command          <= avalon_mm_s.write ? WRITE_REQ : READ_REQ;
                     r_req.address          <= avalon_mm_s.address;
                     r_req.operation_status <= '0;
                     r_req.byte_en          <= avalon_mm_s.byteenable;
                     r_req.data             <= avalon_mm_s.writedata
                                               & be_mask(avalon_mm_s.byteenable);
                     r_req_valid            <= 1'b1;
                     r_state                <= SEND;
                  end
               end
            end
            SEND: begin
               if (req_ack) begin
                  r_req_valid <= 1'b0;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               // Timeout and link loss take priority over any response this cycle.
               if (w_timeout || !w_link_up || (w_crc && !w_retry_ok)) begin
                  r_resp    <= AVMM_RESP_SLVERR;
                  r_rdata   <= '0;
                  r_waitreq <= 1'b0;
                  r_rdv     <= !w_is_write;
                  r_state   <= DONE;
               end else if (w_match) begin
                  r_resp    <= (resp.operation_status == '0) ? AVMM_RESP_OKAY
                                                             : AVMM_RESP_SLVERR;
                  r_rdata   <= resp.data & be_mask(r_req.byte_en);
                  r_waitreq <= 1'b0;
                  r_rdv     <= !w_is_write;
                  r_state   <= DONE;
               end else if (w_crc) begin
                  r_retry     <= r_retry + 1'b1;
                  r_req_valid <= 1'b1;
                  r_state     <= SEND;
               end
            end
            DONE: begin
               r_waitreq <= 1'b1;
               r_rdv     <= 1'b0;
               r_tag     <= r_tag + 1'b1;
               r_retry   <= '0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req                       = r_req;
   assign req_valid                 = r_req_valid;
   assign avalon_mm_s.waitrequest   = r_waitreq;
   assign avalon_mm_s.readdatavalid = r_rdv;
   assign avalon_mm_s.readdata      = r_rdata;
   assign avalon_mm_s.response      = r_resp;

endmodule
